// File: rtl/float2fix_pipe_if.sv
// Handshake bundle for float2fix_pipe: float request channel and fixed-point result channel.
// The master drives the request and out_ready; the slave (converter) drives the rest.
interface float2fix_pipe_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned FIX_W = 32,
    parameter int unsigned POS_W = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [EXP_W+MAN_W:0]   floatn;
    logic [POS_W-1:0]       fixposition;
    logic                   out_valid;
    logic                   out_ready;
    logic [FIX_W-1:0]       fixn;
    logic                   out_ovf;
    logic                   out_nan;
    logic                   out_inexact;

    modport master (
        output in_valid, floatn, fixposition, out_ready,
        input  in_ready, out_valid, fixn, out_ovf, out_nan, out_inexact
    );

    modport slave (
        input  in_valid, floatn, fixposition, out_ready,
        output in_ready, out_valid, fixn, out_ovf, out_nan, out_inexact
    );
endinterface

// File: rtl/float2fix_pipe.sv
// 3-stage float to signed fixed-point converter: unpack/classify, align-shift, sign/saturate.
// Define F2F_ROUND_NEAREST_EN for round-half-to-even; otherwise the magnitude is truncated.
module float2fix_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned FIX_W = 32,
    parameter int unsigned POS_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    float2fix_pipe_if.slave  bus
);
    localparam int unsigned SW    = MAN_W + 1;
    localparam int unsigned LW    = FIX_W + 1;
    localparam int          BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int          MAN_I = int'(MAN_W);
    localparam int          SW_I  = int'(SW);
    localparam int          LW_I  = int'(LW);

    localparam logic [LW:0]      POS_LIM = {3'b000, {(FIX_W-1){1'b1}}};
    localparam logic [LW:0]      NEG_LIM = {3'b001, {(FIX_W-1){1'b0}}};
    localparam logic [FIX_W-1:0] POS_SAT = {1'b0, {(FIX_W-1){1'b1}}};
    localparam logic [FIX_W-1:0] NEG_SAT = {1'b1, {(FIX_W-1){1'b0}}};

    typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

    logic adv;

    // S1 signals
    logic              sign_f;
    logic [EXP_W-1:0]  exp_f;
    logic [MAN_W-1:0]  man_f;
    logic [POS_W-1:0]  fp;
    cls_e              cls_d;
    logic signed [31:0] sh_d;

    logic              v1_q, sign1_q;
    cls_e              cls1_q;
    logic [SW-1:0]     sig1_q;
    logic signed [31:0] sh1_q;

    // S2 signals
    logic signed [31:0] top_pos, rsh;
    logic [2*SW-1:0]   rtmp;
    logic [LW-1:0]     mag_d;
    logic              big_d, guard_d, sticky_d;

    logic              v2_q, sign2_q, big2_q;
    cls_e              cls2_q;
    logic [LW-1:0]     mag2_q;
`ifdef F2F_ROUND_NEAREST_EN
    logic              guard2_q, sticky2_q;
`else
    logic              inx2_q;
`endif

    // S3 signals
    logic [LW:0]       m2;
    logic              inx2, sat;
    logic [FIX_W-1:0]  fixn_d;
    logic              ovf_d, nan_d, inx_d;

    logic              ov_q, ovf_q, nan_q, inx_q;
    logic [FIX_W-1:0]  fixn_q;

    // Whole pipe moves in lockstep; a stalled output freezes every stage.
    assign adv          = !ov_q || bus.out_ready;
    assign bus.in_ready = adv;

    assign {sign_f, exp_f, man_f} = bus.floatn;
    assign fp = bus.fixposition;

    always_comb begin
        cls_d = ClsNorm;
        if (exp_f == '0) begin
            cls_d = ClsZero;
        end else if (&exp_f) begin
            cls_d = (man_f == '0) ? ClsInf : ClsNan;
        end
        // Integer LSB weight of the significand: 2^(e - bias + fixposition - MAN_W).
        sh_d = $signed(32'(exp_f)) + $signed(32'(fp)) - BIAS - MAN_I;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            cls1_q  <= ClsZero;
            sig1_q  <= '0;
            sh1_q   <= '0;
        end else if (adv) begin
            v1_q    <= bus.in_valid;
            sign1_q <= sign_f;
            cls1_q  <= cls_d;
            sig1_q  <= {1'b1, man_f};
            sh1_q   <= sh_d;
        end
    end

    always_comb begin
        top_pos  = MAN_I + sh1_q;
        rsh      = -sh1_q;
        big_d    = (cls1_q == ClsNorm) && (top_pos >= LW_I);
        mag_d    = '0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        rtmp     = '0;
        if (cls1_q == ClsZero) begin
            sticky_d = |sig1_q[MAN_W-1:0];
        end else if (cls1_q == ClsNorm && !big_d) begin
            if (sh1_q >= 0) begin
                mag_d = LW'(sig1_q) << $unsigned(sh1_q);
            end else if (rsh > SW_I) begin
                // Hidden bit lies below the guard position: only sticky survives.
                sticky_d = 1'b1;
            end else begin
                rtmp     = {sig1_q, {SW{1'b0}}} >> $unsigned(rsh);
                mag_d    = LW'(rtmp[2*SW-1:SW]);
                guard_d  = rtmp[SW-1];
                sticky_d = |rtmp[SW-2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            sign2_q   <= 1'b0;
            big2_q    <= 1'b0;
            cls2_q    <= ClsZero;
            mag2_q    <= '0;
`ifdef F2F_ROUND_NEAREST_EN
            guard2_q  <= 1'b0;
            sticky2_q <= 1'b0;
`else
            inx2_q    <= 1'b0;
`endif
        end else if (adv) begin
            v2_q      <= v1_q;
            sign2_q   <= sign1_q;
            big2_q    <= big_d;
            cls2_q    <= cls1_q;
            mag2_q    <= mag_d;
`ifdef F2F_ROUND_NEAREST_EN
            guard2_q  <= guard_d;
            sticky2_q <= sticky_d;
`else
            inx2_q    <= guard_d | sticky_d;
`endif
        end
    end

`ifdef F2F_ROUND_NEAREST_EN
    logic rnd_up;
    assign rnd_up = (cls2_q == ClsNorm) && guard2_q && (sticky2_q || mag2_q[0]);
    assign inx2   = guard2_q | sticky2_q;
    assign m2     = {1'b0, mag2_q} + (LW+1)'(rnd_up);
`else
    assign inx2   = inx2_q;
    assign m2     = {1'b0, mag2_q};
`endif

    always_comb begin
        fixn_d = '0;
        ovf_d  = 1'b0;
        nan_d  = 1'b0;
        inx_d  = 1'b0;
        sat    = big2_q || (sign2_q ? (m2 > NEG_LIM) : (m2 > POS_LIM));
        case (cls2_q)
            ClsNan:  nan_d = 1'b1;
            ClsZero: inx_d = inx2;
            ClsInf: begin
                ovf_d  = 1'b1;
                fixn_d = sign2_q ? NEG_SAT : POS_SAT;
            end
            default: begin
                inx_d = inx2;
                if (sat) begin
                    ovf_d  = 1'b1;
                    fixn_d = sign2_q ? NEG_SAT : POS_SAT;
                end else begin
                    fixn_d = sign2_q ? -m2[FIX_W-1:0] : m2[FIX_W-1:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q   <= 1'b0;
            fixn_q <= '0;
            ovf_q  <= 1'b0;
            nan_q  <= 1'b0;
            inx_q  <= 1'b0;
        end else if (adv) begin
            ov_q   <= v2_q;
            fixn_q <= fixn_d;
            ovf_q  <= ovf_d;
            nan_q  <= nan_d;
            inx_q  <= inx_d;
        end
    end

    assign bus.out_valid   = ov_q;
    assign bus.fixn        = fixn_q;
    assign bus.out_ovf     = ovf_q;
    assign bus.out_nan     = nan_q;
    assign bus.out_inexact = inx_q;
endmodule

// File: tb/tb_float2fix_pipe.sv
// Scoreboard bench for float2fix_pipe: directed table plus random floats against an
// integer-arithmetic reference model; monitor pops expected results on each output transfer.
module tb_float2fix_pipe;
    typedef struct packed {
        logic [31:0] fixn;
        logic        ovf;
        logic        nan;
        logic        inx;
    } res_t;

    typedef struct {
        logic [31:0] f;
        logic [4:0]  fp;
        res_t        r;
    } dir_t;

    logic clk, rst_n;
    float2fix_pipe_if #(.EXP_W(8), .MAN_W(23), .FIX_W(32), .POS_W(5)) bus ();

    float2fix_pipe #(.EXP_W(8), .MAN_W(23), .FIX_W(32), .POS_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t exp_q[$];
    dir_t dirs[$];
    int   total = 0;
    int   bad   = 0;
    int   rcv   = 0;
    bit   rand_rdy = 0, hold_rdy = 0, bp_arm = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic res_t model(input logic [31:0] f, input int fp);
        res_t         r;
        logic [127:0] sig, mag, rem, lim;
        int           e, sh, d;
        logic         s;
        r = '0;
        s = f[31];
        e = int'(f[30:23]);
        if (e == 255) begin
            if (f[22:0] != 0) r.nan = 1'b1;
            else begin
                r.ovf  = 1'b1;
                r.fixn = s ? 32'h8000_0000 : 32'h7fff_ffff;
            end
            return r;
        end
        if (e == 0) begin
            r.inx = (f[22:0] != 0);
            return r;
        end
        sig = {104'd0, 1'b1, f[22:0]};
        sh  = e - 127 + fp - 23;
        if (sh >= 0) begin
            mag = (sh > 90) ? (128'd1 << 100) : (sig << sh);
        end else begin
            d = -sh;
            if (d >= 100) begin
                mag   = '0;
                r.inx = 1'b1;
            end else begin
                mag   = sig >> d;
                rem   = sig - (mag << d);
                r.inx = (rem != 0);
`ifdef F2F_ROUND_NEAREST_EN
                if ((rem << 1) > (128'd1 << d) || ((rem << 1) == (128'd1 << d) && mag[0]))
                    mag = mag + 1;
`endif
            end
        end
        lim = s ? (128'd1 << 31) : ((128'd1 << 31) - 1);
        if (mag > lim) begin
            r.ovf  = 1'b1;
            r.fixn = s ? 32'h8000_0000 : 32'h7fff_ffff;
        end else begin
            r.fixn = s ? -mag[31:0] : mag[31:0];
        end
        return r;
    endfunction

    task automatic add_dir(input logic [31:0] f, input logic [4:0] fp, input logic [31:0] x,
                           input logic ovf, input logic nan, input logic inx);
        dir_t t;
        t.f = f; t.fp = fp; t.r = '{fixn: x, ovf: ovf, nan: nan, inx: inx};
        dirs.push_back(t);
    endtask

    task automatic send(input logic [31:0] f, input logic [4:0] fp, input res_t r);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.floatn = f;
        bus.fixposition = fp;
        #1;
        while (!bus.in_ready && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(3);
    endtask

    // out_ready updates away from both sampling points.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hold_rdy) bus.out_ready = 1'b0;
            else if (bp_arm && bus.out_valid) begin
                bp_arm = 0;
                bus.out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #2;
                bus.out_ready = 1'b1;
            end else if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
            else bus.out_ready = 1'b1;
        end
    end

    // Monitor: output transfer happens at the next posedge when valid && ready here.
    initial begin
        bit          hold_pending = 0;
        logic [34:0] held = '0;
        res_t        e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (hold_pending)
                    chk("hold_stable", 64'({bus.fixn, bus.out_ovf, bus.out_nan, bus.out_inexact}),
                        64'(held));
                if (bus.out_ready) begin
                    hold_pending = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", 64'(bus.fixn), 64'hdead_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        rcv++;
                        chk("result", 64'({bus.fixn, bus.out_ovf, bus.out_nan, bus.out_inexact}),
                            64'(e));
                    end
                end else begin
                    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                    hold_pending = 1;
                    held = {bus.fixn, bus.out_ovf, bus.out_nan, bus.out_inexact};
                end
            end else begin
                hold_pending = 0;
            end
        end
    end

    initial begin
        logic [31:0] f;
        logic [7:0]  ex;
        logic [22:0] mn;
        logic [4:0]  fp;
        int          rcv0, stale, n;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.floatn = '0;
        bus.fixposition = '0;
        bus.out_ready = 1'b1;

        add_dir(32'hC0E0_0000, 5'd0,  32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0);
        add_dir(32'h3FC0_0000, 5'd4,  32'h0000_0018, 1'b0, 1'b0, 1'b0);
`ifdef F2F_ROUND_NEAREST_EN
        add_dir(32'h3FE0_0000, 5'd1,  32'h0000_0004, 1'b0, 1'b0, 1'b1);
`else
        add_dir(32'h3FE0_0000, 5'd1,  32'h0000_0003, 1'b0, 1'b0, 1'b1);
`endif
        add_dir(32'hC020_0000, 5'd0,  32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1);
        add_dir(32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        add_dir(32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b0, 1'b0, 1'b0);
        add_dir(32'h7F80_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        add_dir(32'hFF80_0000, 5'd0,  32'h8000_0000, 1'b1, 1'b0, 1'b0);
        add_dir(32'h7FC0_0000, 5'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b0);
        add_dir(32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1);
        add_dir(32'h4780_0000, 5'd16, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        add_dir(32'h4F00_0000, 5'd31, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        add_dir(32'h3F00_0000, 5'd0,  32'h0000_0000, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_fixn", 64'(bus.fixn), 64'd0);
        chk("rst_flags", 64'({bus.out_ovf, bus.out_nan, bus.out_inexact}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Latency: presented in cycle 0, visible in cycle 3.
        send(dirs[0].f, dirs[0].fp, dirs[0].r);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("latency_c2", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("latency_c3", 64'(bus.out_valid), 64'd1);
        idle(2);

        for (int i = 1; i < dirs.size(); i++) send(dirs[i].f, dirs[i].fp, dirs[i].r);
        idle(1);
        drain();

        // Backpressure: four back-to-back, four-cycle stall once the first result shows.
        rcv0 = rcv;
        bp_arm = 1;
        for (int i = 0; i < 4; i++) begin
            f = {1'b0, 8'(130 + i), 23'h0};
            send(f, 5'd2, model(f, 2));
        end
        idle(1);
        drain();
        chk("bp_count", 64'(rcv - rcv0), 64'd4);

        rand_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, 19);
            if (n == 0) ex = 8'd0;
            else if (n == 1) ex = 8'hFF;
            else ex = 8'($urandom_range(110, 165));
            n = $urandom_range(0, 2);
            if (n == 0) mn = 23'($urandom);
            else if (n == 1) mn = {3'($urandom), 20'd0};
            else mn = '0;
            fp = 5'($urandom_range(0, 31));
            f = {1'($urandom), ex, mn};
            send(f, fp, model(f, int'(fp)));
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(1);
        drain();
        rand_rdy = 0;

        // Reset with two transactions in flight while the output is stalled.
        hold_rdy = 1;
        idle(2);
        send(32'h4040_0000, 5'd0, model(32'h4040_0000, 0));
        send(32'hC080_0000, 5'd3, model(32'hC080_0000, 3));
        idle(1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_fixn", 64'(bus.fixn), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b1;
        hold_rdy = 0;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/float2fix_pipe.md
Name: float2fix_pipe

Overview:
- Parametrised, pipelined successor to the combinational float-to-fixed converter.
- Converts an IEEE-754-style float (EXP_W/MAN_W) to a signed FIX_W two's-complement fixed-point value. The binary point is selected per transaction.
- Adds valid/ready handshaking, a 3-stage pipeline, saturation and status flags.
- Sits between float-producing datapaths and fixed-point consumers.

Parameters:
- EXP_W, 8, float exponent width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, float mantissa width (fraction bits, hidden 1 implied).
- FIX_W, 32, output fixed-point width, signed.
- POS_W, 5, width of fixposition; must satisfy 2^POS_W <= FIX_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  converter can accept input this cycle.
- floatn  in  1+EXP_W+MAN_W  input float {sign, exponent, mantissa}.
- fixposition  in  POS_W  number of fractional bits in the result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- fixn  out  FIX_W  signed fixed-point result.
- out_ovf  out  1  result saturated.
- out_nan  out  1  input was NaN.
- out_inexact  out  1  nonzero bits were discarded or rounded away.

Behaviour:
- Reset (async, rst_n=0): all stage valids, out_valid, fixn, out_ovf, out_nan and out_inexact clear to 0 immediately. In-flight data is dropped. in_ready reads 1 after reset.
- Pipeline: S1 unpack/classify, S2 align-shift, S3 sign apply/saturate into output registers.
  - Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, which is combinational.
  - All stages shift together when adv=1. Bubbles are not collapsed.
- Acceptance: a transaction is accepted when in_valid && in_ready. fixposition is captured with floatn and travels with it.
- Latency: result appears on out_valid exactly 3 cycles after acceptance when out_ready is held 1. Throughput is 1/cycle.
- Output hold: while out_valid=1 && out_ready=0, fixn and the flags stay stable and no stage advances. Order is always preserved; no transaction is lost or duplicated.
- Arithmetic:
  - result = (-1)^s * 1.m * 2^(e-bias) * 2^fixposition.
  - Magnitude is computed unsigned on FIX_W+1 bits, then the sign is applied.
- Default rounding: truncate toward zero, applied to the magnitude before negation. out_inexact=1 if any shifted-out bit is nonzero.
- Exponent = 0 (zero/denormal): flush to 0. out_inexact=1 only if the mantissa is nonzero.
- Exponent all-ones, mantissa = 0 (infinity): saturate; out_ovf=1.
- Exponent all-ones, mantissa != 0 (NaN): fixn=0, out_nan=1, out_ovf=0.
- Saturation:
  - Positive magnitude > 2^(FIX_W-1)-1 gives 2^(FIX_W-1)-1.
  - Negative magnitude > 2^(FIX_W-1) gives -2^(FIX_W-1).
  - out_ovf=1 in both cases.
  - Exactly -2^(FIX_W-1) is representable: out_ovf=0.
- Left-shift amounts beyond FIX_W must be detected as overflow, never wrapped.
- Flags are mutually consistent: out_nan=1 implies out_ovf=0 and out_inexact=0.

Optional Feature:
- Macro: F2F_ROUND_NEAREST_EN.
- Defined: round half to nearest even on the magnitude in S2/S3.
  - out_inexact=1 if the discarded bits are nonzero.
  - A round-up that exceeds range saturates with out_ovf=1.
  - Latency is unchanged (3).
- Undefined: truncate toward zero as above. No rounding logic is synthesised.

Test Plan:
- 0xC0E00000 (-7.0), fixposition=0, out_ready=1 -> fixn=0xFFFFFFF9 exactly 3 cycles later; ovf=0, nan=0, inexact=0.
- 0x3FC00000 (1.5), fixposition=4 -> fixn=24 (0x18), inexact=0. Then 0x3FE00000 (1.75), fixposition=1:
  - Default -> fixn=3, inexact=1.
  - With F2F_ROUND_NEAREST_EN -> fixn=4, inexact=1.
  - Also 0xC0200000 (-2.5), fixposition=0 -> -2 in both modes.
- 0x4F000000 (2^31), fixposition=0 -> 0x7FFFFFFF, ovf=1. 0xCF000000 (-2^31) -> 0x80000000, ovf=0. 0x7F800000 (+inf) -> 0x7FFFFFFF, ovf=1.
- 0x7FC00000 (NaN) -> fixn=0, nan=1. 0x00000001 (denormal) -> fixn=0, inexact=1.
- Backpressure: 4 back-to-back inputs, out_ready=0 for 4 cycles once out_valid rises -> in_ready=0 while stalled, fixn held stable, all 4 results emerge in order with no drops or duplicates.
- Reset mid-stream: assert rst_n=0 with 2 transactions in flight -> out_valid falls to 0 without a clock edge. After release, in_ready=1 and no stale result appears.
